// File: rtl/lcd_power_seq.sv
// rtl/lcd_power_seq.sv - LCD power/timing/backlight sequencer with debounced pattern select
module lcd_power_seq #(
  parameter int T_PWR_ON        = 16,
  parameter int BL_DELAY_FRAMES = 2,
  parameter int BL_OFF_FRAMES   = 1,
  parameter int T_PWR_OFF       = 8,
  parameter int DEBOUNCE        = 4,
  parameter int N_PATTERNS      = 4
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       en_req,
  input  logic       btn_n,
  input  logic       vsync_n,
  input  logic [7:0] bl_level,
  output logic       panel_pwr,
  output logic       tg_en,
  output logic       bl_pwm,
  output logic [1:0] pattern_sel,
  output logic       ready,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_PWR_UP   = 3'd1,
    S_TG_UP    = 3'd2,
    S_ON       = 3'd3,
    S_BL_DOWN  = 3'd4,
    S_TG_DOWN  = 3'd5,
    S_PWR_DOWN = 3'd6
  } state_t;

  localparam int T_MAX = (T_PWR_ON > T_PWR_OFF) ? T_PWR_ON : T_PWR_OFF;
  localparam int CW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;
  localparam int F_MAX = (BL_DELAY_FRAMES > BL_OFF_FRAMES) ? BL_DELAY_FRAMES : BL_OFF_FRAMES;
  localparam int FW    = $clog2(F_MAX + 1);
  localparam int DW    = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

  localparam logic [CW-1:0] PWR_ON_LAST   = CW'(T_PWR_ON - 1);
  localparam logic [CW-1:0] PWR_OFF_LAST  = CW'(T_PWR_OFF - 1);
  localparam logic [FW-1:0] BL_DELAY_LAST = FW'(BL_DELAY_FRAMES - 1);
  localparam logic [FW-1:0] BL_OFF_LAST   = FW'(BL_OFF_FRAMES - 1);
  localparam logic [DW-1:0] DB_LAST       = DW'(DEBOUNCE - 1);
  localparam logic [1:0]    PAT_LAST      = 2'(N_PATTERNS - 1);

  state_t          state_q;
  state_t          state_next;
  logic [CW-1:0]   cyc_cnt;
  logic [FW-1:0]   frm_cnt;
  logic            vsync_prev;
  logic            fs;
  logic            btn_s1;
  logic            btn_s2;
  logic            btn_db;
  logic [DW-1:0]   db_cnt;
  logic            press;
  logic            pend;
  logic            adv;
  logic [7:0]      pwm_cnt;
  logic            bl_pwm_q;

  assign state = state_q;
  assign fs    = vsync_prev & ~vsync_n;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_OFF;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_OFF:      if (en_req) state_next = S_PWR_UP;
      S_PWR_UP:   if (!en_req) state_next = S_OFF;
                  else if (cyc_cnt == PWR_ON_LAST) state_next = S_TG_UP;
      S_TG_UP:    if (!en_req) state_next = S_TG_DOWN;
                  else if (fs && frm_cnt == BL_DELAY_LAST) state_next = S_ON;
      S_ON:       if (!en_req) state_next = S_BL_DOWN;
      S_BL_DOWN:  if (fs && frm_cnt == BL_OFF_LAST) state_next = S_TG_DOWN;
      S_TG_DOWN:  if (fs) state_next = S_PWR_DOWN;
      S_PWR_DOWN: if (cyc_cnt == PWR_OFF_LAST) state_next = S_OFF;
      default:    state_next = S_OFF;
    endcase
  end

  // bl_pwm is gated by the live state so it drops the cycle the sequencer leaves ON
  always_comb begin
    panel_pwr = 1'b0;
    tg_en     = 1'b0;
    ready     = 1'b0;
    bl_pwm    = 1'b0;
    case (state_q)
      S_PWR_UP, S_PWR_DOWN: panel_pwr = 1'b1;
      S_TG_UP, S_BL_DOWN, S_TG_DOWN: begin
        panel_pwr = 1'b1;
        tg_en     = 1'b1;
      end
      S_ON: begin
        panel_pwr = 1'b1;
        tg_en     = 1'b1;
        ready     = 1'b1;
        bl_pwm    = bl_pwm_q;
      end
      default: ;
    endcase
  end

  // Both counters restart on every state change so each state times from zero
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      cyc_cnt <= '0;
      frm_cnt <= '0;
    end else if (state_next != state_q) begin
      cyc_cnt <= '0;
      frm_cnt <= '0;
    end else begin
      if (state_q == S_PWR_UP || state_q == S_PWR_DOWN)
        cyc_cnt <= cyc_cnt + CW'(1);
      if (fs && (state_q == S_TG_UP || state_q == S_BL_DOWN))
        frm_cnt <= frm_cnt + FW'(1);
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      vsync_prev <= 1'b1;
      pwm_cnt    <= '0;
      bl_pwm_q   <= 1'b0;
    end else begin
      vsync_prev <= vsync_n;
      pwm_cnt    <= pwm_cnt + 8'd1;
      bl_pwm_q   <= (state_q == S_ON) && (pwm_cnt < bl_level);
    end
  end

  assign press = btn_db & ~btn_s2 & (db_cnt == DB_LAST);
  assign adv   = (state_q == S_ON) & fs & pend;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      btn_s1 <= 1'b1;
      btn_s2 <= 1'b1;
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= btn_s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // A press landing on the same cycle as an advance re-arms pend for the next frame
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      pend        <= 1'b0;
      pattern_sel <= '0;
    end else begin
      if (adv)
        pattern_sel <= (pattern_sel == PAT_LAST) ? 2'd0 : pattern_sel + 2'd1;
      if (press)
        pend <= 1'b1;
      else if (adv)
        pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lcd_power_seq.sv
// tb/tb_lcd_power_seq.sv - randomized scoreboard bench for lcd_power_seq
module tb_lcd_power_seq;

  localparam int NMAX            = 4000;
  localparam int T_PWR_ON        = 16;
  localparam int BL_DELAY_FRAMES = 2;
  localparam int BL_OFF_FRAMES   = 1;
  localparam int T_PWR_OFF       = 8;
  localparam int DEBOUNCE        = 4;
  localparam int N_PATTERNS      = 4;

  localparam int OFF = 0, PWR_UP = 1, TG_UP = 2, ON = 3, BL_DOWN = 4, TG_DOWN = 5, PWR_DOWN = 6;

  logic       PixelClk = 1'b0;
  logic       nRST     = 1'b0;
  logic       en_req   = 1'b0;
  logic       btn_n    = 1'b1;
  logic       vsync_n  = 1'b1;
  logic [7:0] bl_level = 8'd0;
  logic       panel_pwr;
  logic       tg_en;
  logic       bl_pwm;
  logic [1:0] pattern_sel;
  logic       ready;
  logic [2:0] state;

  lcd_power_seq #(
    .T_PWR_ON(T_PWR_ON), .BL_DELAY_FRAMES(BL_DELAY_FRAMES), .BL_OFF_FRAMES(BL_OFF_FRAMES),
    .T_PWR_OFF(T_PWR_OFF), .DEBOUNCE(DEBOUNCE), .N_PATTERNS(N_PATTERNS)
  ) dut (
    .PixelClk(PixelClk), .nRST(nRST), .en_req(en_req), .btn_n(btn_n), .vsync_n(vsync_n),
    .bl_level(bl_level), .panel_pwr(panel_pwr), .tg_en(tg_en), .bl_pwm(bl_pwm),
    .pattern_sel(pattern_sel), .ready(ready), .state(state)
  );

  always #5 PixelClk = ~PixelClk;

  typedef struct { int t; int v; } ev_t;
  ev_t st_q[$];
  ev_t pat_q[$];

  bit         en_a [NMAX];
  bit         vs_a [NMAX];
  bit         btn_a[NMAX];
  logic [7:0] lvl_a[NMAX];
  int         exp_st[NMAX];

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, int t, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, t, act, exp);
    end
  endtask

  function automatic bit fs_at(int q);
    bit prev;
    prev = (q == 0) ? 1'b1 : vs_a[q-1];
    return prev & ~vs_a[q];
  endfunction

  // kind 0: en_req high, 1: en_req low, 2: frame start
  function automatic int find(int from, int n, int kind);
    for (int q = from; q < n; q++) begin
      if (kind == 0 && en_a[q]) return q;
      if (kind == 1 && !en_a[q]) return q;
      if (kind == 2 && fs_at(q)) return q;
    end
    return n;
  endfunction

  function automatic bit samp(int k);
    return (k >= 2) ? btn_a[k-2] : 1'b1;
  endfunction

  task automatic gen(int n, bit abort_prefix);
    int t, len, per;
    logic [7:0] lv;
    t = 0;
    while (t < n) begin
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 80)) : int'($urandom_range(10, 16));
      for (int i = 0; i < per && t < n; i++) begin
        vs_a[t] = (i >= 2);
        t++;
      end
    end
    for (int i = 0; i < n; i++) en_a[i] = 1'b0;
    t = 3;
    if (abort_prefix) begin
      for (int i = 3; i < 10; i++) en_a[i] = 1'b1;
      t = 15;
    end
    while (t < n) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 60)) : int'($urandom_range(400, 1000));
      for (int i = 0; i < len && t < n; i++) begin
        en_a[t] = 1'b1;
        t++;
      end
      len = ($urandom_range(0, 2) == 0) ? 5 : int'($urandom_range(10, 120));
      t = t + len;
    end
    for (int b = 0; b < n; b = b + 300) begin
      case ($urandom_range(0, 3))
        0:       lv = 8'd0;
        1:       lv = 8'd64;
        2:       lv = 8'd255;
        default: lv = 8'($urandom_range(1, 254));
      endcase
      for (int i = b; i < b + 300 && i < n; i++) lvl_a[i] = lv;
    end
    for (int i = 0; i < n; i++) btn_a[i] = 1'b1;
    t = 5;
    while (t < n) begin
      t = t + int'($urandom_range(5, 60));
      case ($urandom_range(0, 2))
        0:       len = 3;
        1:       len = 10;
        default: len = int'($urandom_range(2, 40));
      endcase
      for (int i = 0; i < len && t < n; i++) begin
        btn_a[t] = 1'b0;
        t++;
      end
    end
  endtask

  // Walks the power sequence event by event, then replays button/frame rules for pattern changes
  task automatic model(int n);
    int cur, q, qa, f, st, nst, db, pend, pat, prev;
    bit all0, all1, press;
    ev_t e;
    st_q.delete();
    pat_q.delete();
    cur = 0;
    st  = OFF;
    while (cur < n) begin
      case (st)
        OFF: begin
          q = find(cur, n, 0); nst = PWR_UP;
        end
        PWR_UP: begin
          qa = find(cur, n, 1); q = cur + T_PWR_ON - 1; nst = TG_UP;
          if (qa <= q) begin q = qa; nst = OFF; end
        end
        TG_UP: begin
          qa = find(cur, n, 1); f = cur - 1;
          for (int k = 0; k < BL_DELAY_FRAMES; k++) f = find(f + 1, n, 2);
          q = f; nst = ON;
          if (qa <= f) begin q = qa; nst = TG_DOWN; end
        end
        ON: begin
          q = find(cur, n, 1); nst = BL_DOWN;
        end
        BL_DOWN: begin
          f = cur - 1;
          for (int k = 0; k < BL_OFF_FRAMES; k++) f = find(f + 1, n, 2);
          q = f; nst = TG_DOWN;
        end
        TG_DOWN: begin
          q = find(cur, n, 2); nst = PWR_DOWN;
        end
        default: begin
          q = cur + T_PWR_OFF - 1; nst = OFF;
        end
      endcase
      for (int i = (cur > 0 ? cur - 1 : 0); i < q && i < n; i++) exp_st[i] = st;
      if (q < n) begin
        e.t = q; e.v = nst;
        st_q.push_back(e);
        exp_st[q] = nst;
      end
      st  = nst;
      cur = q + 1;
    end
    db = 1; pend = 0; pat = 0;
    for (int q2 = 0; q2 < n; q2++) begin
      all0 = 1'b1; all1 = 1'b1;
      for (int k = q2 - DEBOUNCE + 1; k <= q2; k++) begin
        if (samp(k)) all0 = 1'b0; else all1 = 1'b0;
      end
      press = 1'b0;
      if (db == 1 && all0) begin db = 0; press = 1'b1; end
      else if (db == 0 && all1) db = 1;
      prev = (q2 > 0) ? exp_st[q2-1] : OFF;
      if (prev == ON && fs_at(q2) && pend == 1) begin
        pat = (pat + 1) % N_PATTERNS;
        e.t = q2; e.v = pat;
        pat_q.push_back(e);
        pend = 0;
      end
      if (press) pend = 1;
    end
  endtask

  task automatic drive_phase(int n);
    for (int t = 0; t < n; t++) begin
      en_req   = en_a[t];
      vsync_n  = vs_a[t];
      btn_n    = btn_a[t];
      bl_level = lvl_a[t];
      @(posedge PixelClk);
      @(negedge PixelClk);
    end
  endtask

  task automatic monitor_phase(int n);
    int prev_st, prev_pat, es, ep, exp_o, act_o, left;
    bit exp_pwm;
    ev_t e;
    prev_st  = OFF;
    prev_pat = 0;
    for (int t = 0; t < n; t++) begin
      @(posedge PixelClk);
      #1;
      if (int'(state) != prev_st) begin
        if (st_q.size() == 0) begin
          chk("state_unexpected", t, int'(state), prev_st);
        end else begin
          e = st_q.pop_front();
          chk("state_time", t, t, e.t);
          chk("state_code", t, int'(state), e.v);
        end
        prev_st = int'(state);
      end
      if (int'(pattern_sel) != prev_pat) begin
        if (pat_q.size() == 0) begin
          chk("pattern_unexpected", t, int'(pattern_sel), prev_pat);
        end else begin
          e = pat_q.pop_front();
          chk("pattern_time", t, t, e.t);
          chk("pattern_value", t, int'(pattern_sel), e.v);
        end
        prev_pat = int'(pattern_sel);
      end
      es      = exp_st[t];
      ep      = (t > 0) ? exp_st[t-1] : OFF;
      exp_pwm = (es == ON) && (ep == ON) && ((t % 256) < int'(lvl_a[t]));
      exp_o   = ((es >= 1 && es <= 6) ? 8 : 0) + ((es >= 2 && es <= 5) ? 4 : 0) +
                ((es == ON) ? 2 : 0) + (exp_pwm ? 1 : 0);
      act_o   = {28'd0, panel_pwr, tg_en, ready, bl_pwm};
      chk("outputs_pwr_tg_rdy_pwm", t, act_o, exp_o);
    end
    left = 0;
    foreach (st_q[i]) if (st_q[i].t < n) left++;
    chk("state_events_missed", n, left, 0);
    left = 0;
    foreach (pat_q[i]) if (pat_q[i].t < n) left++;
    chk("pattern_events_missed", n, left, 0);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_state"}, -1, int'(state), 0);
    chk({tag, "_panel_pwr"}, -1, int'(panel_pwr), 0);
    chk({tag, "_tg_en"}, -1, int'(tg_en), 0);
    chk({tag, "_bl_pwm"}, -1, int'(bl_pwm), 0);
    chk({tag, "_ready"}, -1, int'(ready), 0);
    chk({tag, "_pattern_sel"}, -1, int'(pattern_sel), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int tr;
    nRST = 1'b0;
    repeat (3) @(negedge PixelClk);
    check_reset("reset_initial");
    gen(3000, 1'b0);
    model(3000);
    tr = 2999;
    for (int t = 800; t < 3000; t++) begin
      if (exp_st[t] == TG_DOWN) begin
        tr = t;
        break;
      end
    end
    nRST = 1'b1;
    fork
      drive_phase(tr + 1);
      monitor_phase(tr + 1);
    join
    st_q.delete();
    pat_q.delete();
    nRST = 1'b0;
    #1;
    check_reset("reset_midseq");
    repeat (2) @(negedge PixelClk);
    gen(2500, 1'b1);
    model(2500);
    nRST = 1'b1;
    fork
      drive_phase(2500);
      monitor_phase(2500);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
